// File: rtl/sram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_pkg
// Shared constants and types for the SRAM port arbiter:
//   - default SRAM geometry (word width, word address width)
//   - maximum channel count and fixed channel indices
//   - arbiter FSM state encoding
//   - ring_idx(): modular channel-index helper used by the round-robin logic
// ---------------------------------------------------------------------------
package sram_port_arbiter_pkg;

    localparam int SRAM_DATA_BIT_DEF = 128;
    localparam int SRAM_ADDR_BIT_DEF = 10;
    localparam int CH_NUM_MAX        = 8;

    localparam int CH_MEM = 0;
    localparam int CH_IF  = 1;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // (base + off) mod n for base < n and off < n, without a divider.
    function automatic int ring_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// ---------------------------------------------------------------------------
// sram_arb_pick
// Combinational winner selection: eligible request vector + round-robin
// pointer -> one-hot grant (all zeros when nothing is eligible).
// Build option SRAM_ARB_RR_EN:
//   defined   : round-robin, scan ascending from i_ptr, wrapping mod CH_NUM
//   undefined : fixed priority, lowest index wins, i_ptr ignored
// Ports:
//   i_req  [CH_NUM]  eligible requests
//   i_ptr  [PTR_W]   round-robin start channel
//   o_gnt  [CH_NUM]  one-hot winner
// ---------------------------------------------------------------------------
module sram_arb_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int PTR_W  = 1
)(
    input  logic [CH_NUM-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [CH_NUM-1:0] o_gnt
);

`ifdef SRAM_ARB_RR_EN
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!w_found && i_req[ring_idx(int'(i_ptr), i, CH_NUM)]) begin
                o_gnt[ring_idx(int'(i_ptr), i, CH_NUM)] = 1'b1;
                w_found = 1'b1;
            end
        end
    end
`else
    // The pointer has no meaning for fixed priority.
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Isolate the lowest set bit.
    assign o_gnt = i_req & (~i_req + CH_NUM'(1));
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Multiplexes CH_NUM cache refill/writeback masters onto one single-port
// block-memory port. Read data comes back RD_LATENCY cycles after the grant,
// tagged with the issuing channel on rvalid_o. A master may hold lock_i to
// keep the port for back-to-back beats.
// Build option SRAM_ARB_RR_EN: round-robin arbitration when defined, fixed
// priority (lowest index wins) when undefined.
// Ports:
//   clk_sys_i, rst_sys_i (async, active-low)
//   req_i/we_i/lock_i [CH_NUM]         per-channel request, direction, lock
//   addr_i  [CH_NUM*SRAM_ADDR_BIT]     flattened addresses, ch0 in LSBs
//   wdata_i [CH_NUM*SRAM_DATA_BIT]     flattened write data, ch0 in LSBs
//   gnt_o   [CH_NUM]                   one-hot combinational accept
//   rvalid_o[CH_NUM], rdata_o          read response, shared data bus
//   sram_ena_o/wea_o/addr_o/data_o     SRAM command port
//   sram_data_i                        SRAM read data
//
// Handshake: a channel raises req_i[k] with we_i/lock_i/addr/wdata stable and
// holds them until gnt_o[k]; a beat transfers in the cycle where req_i[k] and
// gnt_o[k] are both high. gnt_o is at most one-hot and never set without req.
// Reads have no back-pressure: rvalid_o[k] is a single-cycle pulse.
// ---------------------------------------------------------------------------
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int CH_NUM        = 2,
    parameter int SRAM_DATA_BIT = SRAM_DATA_BIT_DEF,
    parameter int SRAM_ADDR_BIT = SRAM_ADDR_BIT_DEF,
    parameter int RD_LATENCY    = 1
)(
    input  logic                              clk_sys_i,
    input  logic                              rst_sys_i,
    input  logic [CH_NUM-1:0]                 req_i,
    input  logic [CH_NUM-1:0]                 we_i,
    input  logic [CH_NUM-1:0]                 lock_i,
    input  logic [CH_NUM*SRAM_ADDR_BIT-1:0]   addr_i,
    input  logic [CH_NUM*SRAM_DATA_BIT-1:0]   wdata_i,
    output logic [CH_NUM-1:0]                 gnt_o,
    output logic [CH_NUM-1:0]                 rvalid_o,
    output logic [SRAM_DATA_BIT-1:0]          rdata_o,
    output logic                              sram_ena_o,
    output logic                              sram_wea_o,
    output logic [SRAM_ADDR_BIT-1:0]          sram_addr_o,
    output logic [SRAM_DATA_BIT-1:0]          sram_data_o,
    input  logic [SRAM_DATA_BIT-1:0]          sram_data_i
);

    localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    arb_state_e         r_state;
    logic [CH_NUM-1:0]  r_owner;
    logic [CH_NUM-1:0]  r_tag [RD_LATENCY];
    logic [CH_NUM-1:0]  w_elig;
    logic [CH_NUM-1:0]  w_gnt;
    logic [PTR_W-1:0]   w_ptr;
    logic               w_xfer;
    logic               w_lock_beat;

    // Grants are suppressed while reset is asserted, since gnt_o is
    // combinational and must read zero during reset. In LOCKED only the
    // owner may win.
    assign w_elig = !rst_sys_i           ? '0 :
                    (r_state == LOCKED)  ? (req_i & r_owner) :
                                           req_i;

    sram_arb_pick #(
        .CH_NUM (CH_NUM),
        .PTR_W  (PTR_W)
    ) u_pick (
        .i_req  (w_elig),
        .i_ptr  (w_ptr),
        .o_gnt  (w_gnt)
    );

    assign gnt_o       = w_gnt;
    assign w_xfer      = |w_gnt;
    assign w_lock_beat = |(w_gnt & lock_i);

    // One-hot grant -> SRAM command mux.
    always_comb begin
        sram_wea_o  = 1'b0;
        sram_addr_o = '0;
        sram_data_o = '0;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            if (w_gnt[ch]) begin
                sram_wea_o  = we_i[ch];
                sram_addr_o = addr_i[ch*SRAM_ADDR_BIT +: SRAM_ADDR_BIT];
                sram_data_o = wdata_i[ch*SRAM_DATA_BIT +: SRAM_DATA_BIT];
            end
        end
    end
    assign sram_ena_o = w_xfer;

    // Lock FSM. A locked owner that drops req_i simply idles the port and
    // keeps ownership; only an owner beat with lock_i=0 releases it.
    always_ff @(posedge clk_sys_i or negedge rst_sys_i) begin
        if (!rst_sys_i) begin
            r_state <= ARB;
            r_owner <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_xfer && w_lock_beat) begin
                        r_state <= LOCKED;
                        r_owner <= w_gnt;
                    end
                end
                LOCKED: begin
                    if (w_xfer && !w_lock_beat) begin
                        r_state <= ARB;
                        r_owner <= '0;
                    end
                end
                default: begin
                    r_state <= ARB;
                    r_owner <= '0;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_RR_EN
    logic [PTR_W-1:0] r_ptr;
    int               w_win;

    always_comb begin
        w_win = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_gnt[i]) w_win = i;
        end
    end

    // The pointer follows every ARB transfer (including the locking beat),
    // freezes while locked, and moves again on the unlocking beat.
    always_ff @(posedge clk_sys_i or negedge rst_sys_i) begin
        if (!rst_sys_i) begin
            r_ptr <= '0;
        end else if (w_xfer && ((r_state == ARB) || !w_lock_beat)) begin
            r_ptr <= PTR_W'(ring_idx(w_win, 1, CH_NUM));
        end
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Read tag pipe: the issuing channel travels alongside the SRAM access
    // so the response lines up with sram_data_i. Reset flushes it.
    always_ff @(posedge clk_sys_i or negedge rst_sys_i) begin
        if (!rst_sys_i) begin
            for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_gnt & ~we_i;
            for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign rvalid_o = r_tag[RD_LATENCY-1];
    assign rdata_o  = sram_data_i;

endmodule
